// File: rtl/cache_pkg.sv
// Geometry, address layout and FSM encoding shared by the write-back D-cache files.
package cache_pkg;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int TAG_W       = 25;
  localparam int IDX_W       = 3;
  localparam int OFS_W       = 2;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = WORD_W * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFS_W-1:0] ofs;
  } addr_t;
endpackage

// File: rtl/cache_line_array.sv
// Line storage (valid/dirty/tag/data): combinational read, word write that sets dirty, block fill.
// Writes land on the rising edge; a fill wins over a word write to keep the line clean.
module cache_line_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFS_W-1:0]  wr_ofs,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data
);
  logic [NUM_BLOCKS-1:0] valid_bits;
  logic [NUM_BLOCKS-1:0] dirty_bits;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (fill_en) begin
      valid_bits[fill_idx] <= 1'b1;
      dirty_bits[fill_idx] <= 1'b0;
      tag_mem[fill_idx]    <= fill_tag;
      data_mem[fill_idx]   <= fill_data;
    end else if (wr_en) begin
      dirty_bits[wr_idx] <= 1'b1;
      data_mem[wr_idx][{wr_ofs, 5'b0} +: WORD_W] <= wr_word;
    end
  end

  assign rd_valid = valid_bits[rd_idx];
  assign rd_dirty = dirty_bits[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate D-cache: hits in 0 cycles, misses stall the pipeline.
// Memory side is a Moore request held until a one-cycle mem_ready; a dirty victim is written back first.
module dcache_wb
  import cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic          proc_stall,
  output logic [31:0]   proc_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
);
  addr_t             a;
  state_t            state;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic              hit;
  logic              req;

  assign a   = proc_addr;
  assign req = proc_read | proc_write;
  assign hit = line_valid && (line_tag == a.tag);

  cache_line_array u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (a.idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     ((state == IDLE) && proc_write && hit),
    .wr_idx    (a.idx),
    .wr_ofs    (a.ofs),
    .wr_word   (proc_wdata),
    .fill_en   ((state == ALLOCATE) && mem_ready),
    .fill_idx  (a.idx),
    .fill_tag  (a.tag),
    .fill_data (mem_rdata)
  );

  assign proc_stall = (state != IDLE) | (req & ~hit);
  assign proc_rdata = line_data[{a.ofs, 5'b0} +: WORD_W];

  // Memory strobes are registered alongside the state so they are pure functions of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          if (line_valid && line_dirty) begin
            state     <= WRITEBACK;
            mem_write <= 1'b1;
          end else begin
            state    <= ALLOCATE;
            mem_read <= 1'b1;
          end
        end
        WRITEBACK: if (mem_ready) begin
          state     <= ALLOCATE;
          mem_write <= 1'b0;
          mem_read  <= 1'b1;
        end
        ALLOCATE: if (mem_ready) begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WRITEBACK: begin
        mem_addr  = {line_tag, a.idx};
        mem_wdata = line_data;
      end
      ALLOCATE: mem_addr = proc_addr[29:2];
      default: ;
    endcase
  end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache serving the pipeline's D-cache port. It sits directly downstream of the MEM stage: it consumes the pipeline's read/write requests, and returns read data plus a stall that freezes the pipeline. Upstream, it talks to a slow 128-bit-wide main memory through a request/ready handshake. Its capacity is 8 blocks × 4 words (128 bytes).

## Interface
- NUM_BLOCKS, 8: lines in the cache; the index is 3 bits.
- BLOCK_WORDS, 4: 32-bit words per line; the offset is 2 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  read request from the MEM stage.
- proc_write  in  1  write request from the MEM stage.
- proc_addr  in  30  word address: tag [29:5], index [4:2], offset [1:0].
- proc_wdata  in  32  store data.
- proc_stall  out  1  holds the pipeline; the request must stay stable while this is high.
- proc_rdata  out  32  load data; valid when proc_read=1 and proc_stall=0.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block writeback request.
- mem_addr  out  28  block address {tag, index}.
- mem_wdata  out  128  writeback block; word 0 is in bits [31:0].
- mem_rdata  in  128  fetched block; same word order as mem_wdata.
- mem_ready  in  1  one-cycle pulse that completes the current mem_read or mem_write.

## Operation
- Per-line storage: valid, dirty, 25-bit tag, 128-bit data.
- hit = valid[idx] and tag[idx] == proc_addr[29:5].
- req = proc_read | proc_write. Both high at once is illegal and unverified; write takes priority.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE with no request: no state change.
- IDLE with a read hit: proc_rdata = data[idx] word[offset], combinational; proc_stall=0.
- IDLE with a write hit: the word at [offset] takes proc_wdata at the edge, dirty[idx] is set, proc_stall=0.
- IDLE with a miss on a line that is not (valid and dirty): proc_stall=1; go to ALLOCATE.
- IDLE with a miss on a line that is valid and dirty: proc_stall=1; go to WRITEBACK.
- WRITEBACK:
  - Outputs: mem_write=1, mem_addr={tag[idx], idx}, mem_wdata=data[idx].
  - On mem_ready, go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: data[idx] ← mem_rdata, tag ← proc tag, valid=1, dirty=0, go to IDLE.
- After ALLOCATE, the retried request hits in IDLE. A write then merges into the line and sets dirty.
- mem_read and mem_write are decoded from the state register only (Moore). They are never both high.
- proc_stall = (state != IDLE) | (req & ~hit).
- proc_rdata is don't-care when not a read hit.
- Outside WRITEBACK and ALLOCATE, mem_addr and mem_wdata are 0.

## Timing
- Reset values: state IDLE, all valid/dirty/tag/data 0, mem_read=0, mem_write=0, proc_stall=0 (with no request), mem_addr=0, mem_wdata=0.
- Hit latency is 0 cycles; the pipeline does not stall.
- Clean miss: mem_read rises 1 cycle after the request appears. Memory replies with mem_ready k cycles after mem_read rises (k≥0; mem_ready may coincide with the first mem_read cycle). proc_stall falls the cycle after mem_ready. Total stall = k+2 cycles.
- Dirty miss: the stall adds the WRITEBACK duration (k_wb+1 cycles) ahead of ALLOCATE.
- mem_ready is ignored in IDLE.
- mem_read and mem_write stay high continuously until the edge where mem_ready is sampled high. They drop the following cycle.
- Reset mid-operation: everything returns to reset values immediately (asynchronously); mem_read and mem_write drop the same instant; dirty data is discarded.
- Index wrap: addresses that differ only in tag map to the same line and evict each other; there is no associativity.

## Structure
- Shared package `cache_pkg`:
  - NUM_BLOCKS, BLOCK_WORDS, TAG_W=25, IDX_W=3, OFS_W=2.
  - State encoding: IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2.
- Sub-module `cache_line_array`: valid/dirty/tag/data storage with async reset. Ports: one combinational read port, a word-write port, and a block-fill port.
- Top-level `dcache_wb` holds the FSM, hit logic and output muxing.

## Test plan
- Cold read to 0x0000_0010, memory k=3, block {0x44,0x33,0x22,0x11} → mem_read asserts with mem_addr=0x0000004. proc_stall is high for 5 cycles. proc_rdata=0x11 (offset 0).
- Write 0xDEAD to 0x0000_0011 after that fill → no stall, dirty[4]=1. A following read of 0x0000_0011 returns 0xDEAD in the same cycle.
- Read 0x0000_0031 (same index 4, tag 1) → WRITEBACK: mem_write=1, mem_addr=0x0000004, mem_wdata word1=0xDEAD. Then ALLOCATE: mem_addr=0x000000C.
- mem_ready in the same cycle mem_read first rises (k=0) → stall exactly 2 cycles; no duplicate fetch.
- Assert rst while in ALLOCATE → mem_read=0 immediately, state IDLE. A re-read of the same address misses again.
- Sweep all 8 indices with reads, then re-read all 8 → the first pass misses on every index; the second pass hits on every index with zero stall.
